// File: rtl/adapt_mul_ctrl_if.sv
// Control/status bundle between the adaptive-multiplier controller and its
// datapath and requester.
//   start            : request one multiplication
//   signA, signB     : MSBs of the A/B shift registers
//   CO_up, CO_down   : shift-counter terminal indications (31 up / 0 down)
//   ldA, ldB, ldY    : parallel loads of the operand and result registers
//   enShrA, enShrB   : shift enables (enShrA also right-shifts the result)
//   cnt_en, countDown: counter enable and direction (1 = down)
//   busy, done       : status; done is a one-cycle result-valid pulse
// The master modport is the controller side.
interface adapt_mul_ctrl_if;
  logic start;
  logic signA;
  logic signB;
  logic CO_up;
  logic CO_down;
  logic ldA;
  logic ldB;
  logic enShrA;
  logic enShrB;
  logic cnt_en;
  logic countDown;
  logic ldY;
  logic busy;
  logic done;

  modport master (
    input  start, signA, signB, CO_up, CO_down,
    output ldA, ldB, enShrA, enShrB, cnt_en, countDown, ldY, busy, done
  );

  modport slave (
    output start, signA, signB, CO_up, CO_down,
    input  ldA, ldB, enShrA, enShrB, cnt_en, countDown, ldY, busy, done
  );
endinterface

// File: rtl/adapt_mul_ctrl.sv
// Controller for a normalize / multiply / denormalize multiplier datapath.
// Operands are left-shifted until their MSB is set, multiplied, and the
// product is right-shifted back by the total shift count kept in a shared
// up/down counter.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, returns to IDLE
//   bus  : adapt_mul_ctrl_if.master (handshake, datapath controls, status)
// Optional feature: define ADAPT_MUL_ZERO_GUARD_EN to let the counter's
// terminal count (CO_up) end normalization of a zero operand. Without it a
// zero operand keeps the controller normalizing until reset.
// Outputs are decoded from the state and the datapath status inputs so that
// shifting stops in the same cycle the leading one arrives.
module adapt_mul_ctrl (
  input  logic             clk,
  input  logic             rst,
  adapt_mul_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    NORM_A = 3'd2,
    NORM_B = 3'd3,
    MULT   = 3'd4,
    DENORM = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic ld_a;
  logic ld_b;
  logic en_shr_a;
  logic en_shr_b;
  logic cnt_en;
  logic count_down;
  logic ld_y;
  logic busy;
  logic done;
  logic stop_a;
  logic stop_b;

`ifdef ADAPT_MUL_ZERO_GUARD_EN
  // Counter saturation ends a normalization that can never see a leading one.
  assign stop_a = bus.signA | bus.CO_up;
  assign stop_b = bus.signB | bus.CO_up;
`else
  logic unused_co_up;
  assign unused_co_up = bus.CO_up;
  assign stop_a = bus.signA;
  assign stop_b = bus.signB;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and output decode.
  always_comb begin
    state_nxt  = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    en_shr_a   = 1'b0;
    en_shr_b   = 1'b0;
    cnt_en     = 1'b0;
    count_down = 1'b0;
    ld_y       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ld_a      = 1'b1;
        ld_b      = 1'b1;
        state_nxt = NORM_A;
      end
      NORM_A: begin
        if (stop_a) begin
          state_nxt = NORM_B;
        end else begin
          en_shr_a = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      NORM_B: begin
        if (stop_b) begin
          state_nxt = MULT;
        end else begin
          en_shr_b = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      MULT: begin
        ld_y      = 1'b1;
        state_nxt = DENORM;
      end
      DENORM: begin
        // Counting back down to zero undoes exactly the normalization shifts.
        count_down = 1'b1;
        if (bus.CO_down) begin
          state_nxt = DONE;
        end else begin
          en_shr_a = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ldA       = ld_a;
  assign bus.ldB       = ld_b;
  assign bus.enShrA    = en_shr_a;
  assign bus.enShrB    = en_shr_b;
  assign bus.cnt_en    = cnt_en;
  assign bus.countDown = count_down;
  assign bus.ldY       = ld_y;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
